// File: rtl/ganesha_pkg.sv
// ---------------------------------------------------------------------------
// ganesha_pkg
// Shared definitions for the Ganesha image ROM row scanner.
//   - Default geometry of the 32x64 Ganesha image ROM (address width, row
//     width, row count) and its default read latency.
//   - Scanner FSM state encoding.
//   - Helper that sizes the ROM latency counter.
// ---------------------------------------------------------------------------
package ganesha_pkg;

    localparam int GANESHA_ADDR_W  = 5;   // ROM address width
    localparam int GANESHA_DATA_W  = 64;  // pixels per ROM row
    localparam int GANESHA_ROWS    = 32;  // rows per frame
    localparam int GANESHA_ROM_LAT = 1;   // ROM read latency in cycles

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } scan_state_t;

    // Width of a counter that runs 0 .. lat-1 (at least one bit).
    function automatic int lat_cnt_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/ganesha_row_piso.sv
// ---------------------------------------------------------------------------
// ganesha_row_piso
// Parallel-in / serial-out register for one ROM row. A load captures a full
// row and clears the column counter; each shift moves the row left by one so
// the MSB is always the current pixel, and advances the column. The column
// counter clears itself when the last column is shifted out, so it never
// wraps through an out-of-range value inside a frame.
//
// Ports
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   i_load       in   1       capture i_load_data, col <= 0 (has priority)
//   i_load_data  in   DATA_W  row word from the ROM
//   i_shift      in   1       pixel handshake: shift left, col++
//   o_msb        out  1       current pixel (shift register MSB)
//   o_eol        out  1       current column is DATA_W-1
// ---------------------------------------------------------------------------
module ganesha_row_piso
    import ganesha_pkg::*;
#(
    parameter int DATA_W = GANESHA_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_shift,
    output logic              o_msb,
    output logic              o_eol
);

    localparam int COL_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_shreg;
    logic [COL_W-1:0]  r_col;
    logic              w_eol;

    assign w_eol = (r_col == COL_W'(DATA_W - 1));

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of its neighbours.
    // NOTE: the row register is datapath, but it is cleared on reset anyway so
    // the pixel output is deterministic straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_col   <= '0;
        end else if (i_load) begin
            r_shreg <= i_load_data;
            r_col   <= '0;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
            r_col   <= w_eol ? '0 : r_col + COL_W'(1);
        end
    end

    assign o_msb = r_shreg[DATA_W-1];
    assign o_eol = w_eol;

endmodule

// File: rtl/ganesha_row_scanner.sv
// ---------------------------------------------------------------------------
// ganesha_row_scanner
// Reads a frame out of the Ganesha image ROM one row at a time and streams it
// as single-bit pixels, MSB first, over a valid/ready interface.
//
// Flow per row: FETCH (rom_en pulse) -> WAIT (ROM_LAT cycles) -> SHIFT
// (DATA_W beats). After the last beat of a row the next row is fetched; after
// the last row a single DONE cycle pulses done and returns to IDLE. There is
// no prefetch, so a bubble of 1+ROM_LAT cycles separates consecutive rows.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       frame request, honoured only in IDLE
//   busy       out  1       frame in progress (FETCH..DONE)
//   done       out  1       one-cycle pulse after the last pixel handshake
//   rom_en     out  1       ROM read enable, high only in FETCH
//   rom_addr   out  ADDR_W  ROM row address (0 while IDLE)
//   rom_data   in   DATA_W  ROM read data
//   pix_valid  out  1       pixel beat valid (SHIFT)
//   pix_ready  in   1       consumer ready; beat transfers on valid & ready
//   pix_data   out  1       current pixel
//   pix_eol    out  1       current beat is the last column of a row
//   pix_eof    out  1       current beat is the last column of the last row
// ---------------------------------------------------------------------------
module ganesha_row_scanner
    import ganesha_pkg::*;
#(
    parameter int ADDR_W  = GANESHA_ADDR_W,
    parameter int DATA_W  = GANESHA_DATA_W,
    parameter int ROWS    = GANESHA_ROWS,
    parameter int ROM_LAT = GANESHA_ROM_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic              pix_eol,
    output logic              pix_eof
);

    localparam int LAT_W = lat_cnt_w(ROM_LAT);

    scan_state_t       r_state;
    scan_state_t       w_next_state;
    logic [ADDR_W-1:0] r_row;
    logic [LAT_W-1:0]  r_lat;

    logic w_lat_last;   // final WAIT cycle: ROM data is valid now
    logic w_last_row;   // current row is ROWS-1
    logic w_beat;       // pixel handshake this cycle
    logic w_row_end;    // handshake on the last column of the row
    logic w_load;       // capture rom_data into the PISO
    logic w_msb;
    logic w_eol;

    assign w_lat_last = (r_lat == LAT_W'(ROM_LAT - 1));
    assign w_last_row = (r_row == ADDR_W'(ROWS - 1));
    assign w_beat     = (r_state == SHIFT) && pix_ready;
    assign w_row_end  = w_beat && w_eol;
    assign w_load     = (r_state == WAIT) && w_lat_last;

    // -----------------------------------------------------------------------
    // Row shift register and column counter
    // -----------------------------------------------------------------------
    ganesha_row_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_load_data (rom_data),
        .i_shift     (w_beat),
        .o_msb       (w_msb),
        .o_eol       (w_eol)
    );

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the next state is defaulted before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                // start is looked at here only; elsewhere it is ignored.
                if (start) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                if (w_lat_last) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_row_end) begin
                    w_next_state = w_last_row ? DONE : FETCH;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Row counter: advances on the last beat of a non-final row, returns to 0
    // in DONE, so a following frame always starts at row 0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
        end else if (r_state == DONE) begin
            r_row <= '0;
        end else if (w_row_end && !w_last_row) begin
            r_row <= r_row + ADDR_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // ROM latency counter: counts WAIT cycles, idles at 0 elsewhere.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat <= '0;
        end else if ((r_state == WAIT) && !w_lat_last) begin
            r_lat <= r_lat + LAT_W'(1);
        end else begin
            r_lat <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registers only, so an asynchronous reset drives
    // them all to 0 immediately. Pixel fields are gated with valid so they
    // read 0 between rows.
    // -----------------------------------------------------------------------
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign rom_en    = (r_state == FETCH);
    assign rom_addr  = (r_state == IDLE) ? '0 : r_row;
    assign pix_valid = (r_state == SHIFT);
    assign pix_data  = pix_valid && w_msb;
    assign pix_eol   = pix_valid && w_eol;
    assign pix_eof   = pix_eol && w_last_row;

endmodule
